// File: rtl/fifo_defs.sv
// Shared definitions for the FIFO write-side front end.
// Holds FSM state encodings and default width constants.
package fifo_defs;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 16;
  localparam int DEF_STAT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLOSE = 2'd2
  } wr_state_e;
endpackage

// File: rtl/write_skid_buffer.sv
// Two-entry in-order skid buffer holding {last_tag, data}.
// Entry 0 is always the head; head outputs are zero when empty.
module write_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_write,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_head_last
);
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_last0;
  logic                  r_last1;
  logic [1:0]            r_count;

  always_ff @(posedge clk_write or negedge reset_n) begin
    if (!reset_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end else begin
            r_data1 <= i_data;
            r_last1 <= i_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // count stays put; a full buffer shifts so order is kept
          if (r_count == 2'd2) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= i_data;
            r_last1 <= i_last;
          end else begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head_data = (r_count != 2'd0) ? r_data0 : '0;
  assign o_head_last = (r_count != 2'd0) && r_last0;
endmodule

// File: rtl/fifo_write_controller.sv
// Write-side front end: skid-buffered producer handshake, burst framing.
// Define WRITE_CTRL_STATS_EN to add stat_words/stat_bursts/stat_stalls.
module fifo_write_controller
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
`ifdef WRITE_CTRL_STATS_EN
  ,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
`endif
) (
  input  logic                  clk_write,
  input  logic                  reset_n,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic                  src_ready,
  input  logic                  flag_full,
  input  logic                  flag_of,
  output logic                  req_write,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic                  burst_active,
  output logic                  burst_done,
  output logic                  err_len,
  output logic                  err_of
`ifdef WRITE_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_words,
  output logic [STAT_WIDTH-1:0] stat_bursts,
  output logic [STAT_WIDTH-1:0] stat_stalls
`endif
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LP_BEAT_LAST = BW'(MAX_BURST - 1);

  wr_state_e       r_state;
  logic [BW-1:0]   r_beat;
  logic            r_done;
  logic            r_active;
  logic            r_err_len;
  logic            r_err_of;

  logic [1:0]            w_count;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_trunc;
  logic                  w_tag;
  logic                  w_close_done;

  assign src_ready    = (r_state != CLOSE) && (w_count != 2'd2);
  assign w_accept     = src_valid && src_ready;
  assign req_write    = (w_count != 2'd0) && !flag_full;
  assign w_pop        = req_write;
  assign w_trunc      = w_accept && !src_last && (r_beat == LP_BEAT_LAST);
  assign w_tag        = src_last || w_trunc;
  assign w_close_done = (r_state == CLOSE) && w_pop && w_head_last;

  write_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_write   (clk_write),
    .reset_n     (reset_n),
    .i_push      (w_accept),
    .i_data      (src_data),
    .i_last      (w_tag),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last)
  );

  always_ff @(posedge clk_write or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_done    <= 1'b0;
      r_active  <= 1'b0;
      r_err_len <= 1'b0;
      r_err_of  <= 1'b0;
    end else begin
      r_done   <= w_close_done;
      r_err_of <= r_err_of | flag_of;
      // active spans the burst through its done cycle
      r_active <= (r_state != IDLE) || w_accept;
      if (w_trunc)
        r_err_len <= 1'b1;
      unique case (r_state)
        IDLE, BURST: begin
          if (w_accept) begin
            r_beat  <= r_beat + BW'(1);
            r_state <= w_tag ? CLOSE : BURST;
          end
        end
        CLOSE: begin
          if (w_close_done) begin
            r_beat  <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_write   = w_head_data;
  assign burst_active = r_active;
  assign burst_done   = r_done;
  assign err_len      = r_err_len;
  assign err_of       = r_err_of;

`ifdef WRITE_CTRL_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_words;
  logic [STAT_WIDTH-1:0] r_stat_bursts;
  logic [STAT_WIDTH-1:0] r_stat_stalls;

  always_ff @(posedge clk_write or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_words  <= '0;
      r_stat_bursts <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_pop && !(&r_stat_words))
        r_stat_words <= r_stat_words + 1'b1;
      if (r_done && !(&r_stat_bursts))
        r_stat_bursts <= r_stat_bursts + 1'b1;
      if ((w_count != 2'd0) && flag_full && !(&r_stat_stalls))
        r_stat_stalls <= r_stat_stalls + 1'b1;
    end
  end

  assign stat_words  = r_stat_words;
  assign stat_bursts = r_stat_bursts;
  assign stat_stalls = r_stat_stalls;
`endif
endmodule

// File: tb/tb_fifo_write_controller.sv
// Bench for fifo_write_controller: directed scenarios plus random traffic.
// A queue-based model predicts every output each cycle.
module tb_fifo_write_controller;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int SW   = 16;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk_write = 1'b0;
  logic          reset_n   = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data  = '0;
  logic          src_last  = 1'b0;
  logic          flag_full = 1'b0;
  logic          flag_of   = 1'b0;
  logic          src_ready;
  logic          req_write;
  logic [DW-1:0] data_write;
  logic          burst_active;
  logic          burst_done;
  logic          err_len;
  logic          err_of;
`ifdef WRITE_CTRL_STATS_EN
  logic [SW-1:0] stat_words;
  logic [SW-1:0] stat_bursts;
  logic [SW-1:0] stat_stalls;
`endif

  always #5 clk_write = ~clk_write;

  fifo_write_controller dut (
    .clk_write    (clk_write),
    .reset_n      (reset_n),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .flag_full    (flag_full),
    .flag_of      (flag_of),
    .req_write    (req_write),
    .data_write   (data_write),
    .burst_active (burst_active),
    .burst_done   (burst_done),
    .err_len      (err_len),
    .err_of       (err_of)
`ifdef WRITE_CTRL_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_bursts  (stat_bursts),
    .stat_stalls  (stat_stalls)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference model: buffer contents as a queue, burst phase as flags
  bit [DW:0] mq[$];
  bit m_burst, m_close, m_done, m_elen, m_eof;
  bit m_acc, m_pop, m_dn, m_tag;
  int m_beats, m_sw, m_sb, m_ss;

  function automatic bit e_ready();
    return !m_close && (mq.size() < 2);
  endfunction

  always @(posedge clk_write or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_burst = 0; m_close = 0; m_done = 0; m_elen = 0; m_eof = 0;
      m_beats = 0; m_sw = 0; m_sb = 0; m_ss = 0;
    end else begin
      cyc++;
      m_acc = src_valid && e_ready();
      m_pop = (mq.size() != 0) && !flag_full;
      m_dn  = m_close && m_pop && mq[0][DW];
      if (mq.size() != 0 && flag_full && m_ss < SMAX) m_ss++;
      if (m_pop && m_sw < SMAX) m_sw++;
      if (m_done && m_sb < SMAX) m_sb++;
      if (flag_of) m_eof = 1;
      if (m_pop) void'(mq.pop_front());
      if (m_dn) begin m_close = 0; m_beats = 0; end
      if (m_acc) begin
        m_beats++;
        m_tag = src_last || (m_beats == MAXB);
        if (m_tag && !src_last) m_elen = 1;
        mq.push_back({m_tag, src_data});
        m_close = m_tag;
        m_burst = !m_tag;
      end
      m_done = m_dn;
    end
  end

  always @(negedge clk_write) begin
    if (reset_n && chk_en) begin
      chk("src_ready", src_ready, e_ready());
      chk("req_write", req_write, (mq.size() != 0) && !flag_full);
      chk("data_write", data_write, (mq.size() != 0) ? mq[0][DW-1:0] : 0);
      chk("burst_active", burst_active, m_burst || m_close || m_done);
      chk("burst_done", burst_done, m_done);
      chk("err_len", err_len, m_elen);
      chk("err_of", err_of, m_eof);
`ifdef WRITE_CTRL_STATS_EN
      chk("stat_words", stat_words, m_sw);
      chk("stat_bursts", stat_bursts, m_sb);
      chk("stat_stalls", stat_stalls, m_ss);
`endif
    end
  end

  // event log for the hand-computed expectations
  logic [DW-1:0] wlog[$];
  int wcyc[$];
  int dlog[$];
  int act_n, full_acc, acc_cyc;

  always @(negedge clk_write) begin
    if (reset_n) begin
      if (req_write) begin wlog.push_back(data_write); wcyc.push_back(cyc); end
      if (burst_done) dlog.push_back(cyc);
      if (burst_active) act_n++;
      if (src_valid && src_ready && flag_full) full_acc++;
    end
  end

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); dlog.delete();
    act_n = 0; full_acc = 0;
  endtask

  task automatic idle(input int n);
    src_valid = 0;
    src_last  = 0;
    repeat (n) @(posedge clk_write);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    bit ok;
    ok = 0;
    src_valid = 1; src_data = d; src_last = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_write);
      ok = src_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk_write);
      #1;
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_ready"}, src_ready, 1);
    chk({tag, "_req_write"}, req_write, 0);
    chk({tag, "_data_write"}, data_write, 0);
    chk({tag, "_burst_active"}, burst_active, 0);
    chk({tag, "_burst_done"}, burst_done, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_err_of"}, err_of, 0);
  endtask

  logic [DW-1:0] va[4];
  int fa;
  bit rdone;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 0;
    #1 chk_reset_vals("rst");
    #20;
    @(posedge clk_write); #1 reset_n = 1;
    chk_en = 1;

    // 4-beat burst, no back-pressure
    clear_logs();
    va[0] = 8'hA1; va[1] = 8'hA2; va[2] = 8'hA3; va[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      send_word(va[i], i == 3);
      if (i == 0) fa = acc_cyc;
    end
    idle(6);
    chk("t1_writes", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("t1_order", wlog[i], va[i]);
    if (wcyc.size() == 4) begin
      chk("t1_first_lat", wcyc[0], fa + 1);
      chk("t1_contig", wcyc[3], wcyc[0] + 3);
    end
    chk("t1_done_n", dlog.size(), 1);
    if (dlog.size() == 1 && wcyc.size() == 4)
      chk("t1_done_cyc", dlog[0], wcyc[3] + 1);

    // full for 6 cycles during a stream
    clear_logs();
    flag_full = 1;
    fork
      for (int i = 0; i < 6; i++) send_word(8'hB0 + 8'(i), i == 5);
      begin repeat (6) @(posedge clk_write); #1 flag_full = 0; end
    join
    idle(6);
    chk("t2_full_acc", full_acc, 2);
    chk("t2_writes", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("t2_order", wlog[i], 8'hB0 + 8'(i));
    chk("t2_err_of", err_of, 0);

    // single-beat burst
    clear_logs();
    send_word(8'hC5, 1);
    idle(5);
    chk("t3_active_cycles", act_n, 2);
    chk("t3_done_n", dlog.size(), 1);

    // 20 beats, last only on beat 20
    chk("t4_err_len_pre", err_len, 0);
    clear_logs();
    for (int i = 0; i < 20; i++) send_word(8'h40 + 8'(i), i == 19);
    idle(5);
    chk("t4_err_len", err_len, 1);
    chk("t4_done_n", dlog.size(), 2);
    chk("t4_writes", wlog.size(), 20);

    // reset with two words buffered
    flag_full = 1;
    send_word(8'hE0, 0);
    send_word(8'hE1, 0);
    src_valid = 0;
    @(negedge clk_write);
    chk("t5_pre_ready", src_ready, 0);
    @(posedge clk_write); #2 reset_n = 0;
    #1 chk_reset_vals("t5");
    flag_full = 0;
    #10;
    @(posedge clk_write); #1 reset_n = 1;
    clear_logs();
    for (int i = 0; i < 3; i++) send_word(8'hF1 + 8'(i), i == 2);
    idle(5);
    chk("t5_writes", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk("t5_order", wlog[i], 8'hF1 + 8'(i));

    // random traffic with random back-pressure
    rdone = 0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          int len;
          len = $urandom_range(1, 20);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            send_word(DW'($urandom), i == len - 1);
          end
        end
        src_valid = 0;
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk_write); #1;
          flag_full = ($urandom_range(0, 3) == 0);
        end
        flag_full = 0;
      end
    join
    idle(8);

    flag_of = 1;
    @(posedge clk_write); #1 flag_of = 0;
    @(negedge clk_write);
    chk("of_sticky", err_of, 1);

`ifdef WRITE_CTRL_STATS_EN
    @(posedge clk_write); #1 reset_n = 0;
    #10;
    @(posedge clk_write); #1 reset_n = 1;
    chk("st_words_rst", stat_words, 0);
    chk("st_bursts_rst", stat_bursts, 0);
    chk("st_stalls_rst", stat_stalls, 0);
    flag_full = 1;
    send_word(8'h10, 0);
    src_valid = 0;
    repeat (4) @(posedge clk_write);
    #1 flag_full = 0;
    for (int i = 1; i < 5; i++) send_word(8'h10 + 8'(i), i == 4);
    idle(3);
    for (int b = 1; b < 3; b++) begin
      for (int i = 0; i < 5; i++) send_word(8'(16 * b + i), i == 4);
      idle(3);
    end
    idle(4);
    chk("st_words", stat_words, 15);
    chk("st_bursts", stat_bursts, 3);
    chk("st_stalls", stat_stalls, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
